// File: rtl/csdf_acc_nch.sv
// csdf_acc_nch: N-channel cyclo-static accumulator actor.
//
// Each of NCH input FIFOs carries an independent flow. Every CNT tokens
// consumed from one channel produce one output token {tag, sum} on a single
// shared output FIFO. Per-channel contexts (count, partial sum) live in
// registers. A round-robin arbiter shares one adder across all channels.
//
// Optional feature (compile-time macro): CSDF_ACC_SAT_EN
//   defined   : accumulation saturates at 2^ACC_W-1
//   undefined : accumulation wraps modulo 2^ACC_W
//
// Ports:
//   ck        in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   in_data   in   NCH*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   in_empty  in   NCH, per-channel FIFO empty flag
//   in_read   out  NCH, per-channel FIFO pop (one-hot or zero)
//   out_full  in   output FIFO full flag
//   out_wr    out  output FIFO push
//   out_data  out  TAG_W+ACC_W, {tag, sum}; zero when out_wr is low
module csdf_acc_nch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 34,
  parameter int unsigned NCH    = 4,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned CNT    = 4
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic [NCH*DATA_W-1:0]  in_data,
  input  logic [NCH-1:0]         in_empty,
  output logic [NCH-1:0]         in_read,
  input  logic                   out_full,
  output logic                   out_wr,
  output logic [TAG_W+ACC_W-1:0] out_data
);

  localparam int unsigned CntW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(CNT - 1);
  localparam logic [TAG_W-1:0] PtrLast = TAG_W'(NCH - 1);

  // Per-channel contexts and the round-robin pointer.
  logic [CntW-1:0]  cnt_q [NCH];
  logic [CntW-1:0]  cnt_d [NCH];
  logic [ACC_W-1:0] acc_q [NCH];
  logic [ACC_W-1:0] acc_d [NCH];
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;

  // Eligibility. Gated by rst so outputs drop at once while reset is low,
  // independent of the input flags.
  logic [NCH-1:0] elig;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NCH; k++) begin
      elig[k] = rst & ~in_empty[k] & ((cnt_q[k] != CntLast) | ~out_full);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NCH-1 so the scan
  // index never leaves 0..NCH-1 even when NCH is not a power of two.
  logic             grant_vld;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] scan_idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = rr_ptr_q;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == PtrLast) ? '0 : scan_idx + TAG_W'(1);
    end
  end

  // Shared adder on the granted channel.
  logic [DATA_W-1:0] in_sel;
  logic [ACC_W-1:0]  in_ext;
  logic [ACC_W-1:0]  acc_sel;
  logic [ACC_W-1:0]  sum;
  logic              last;
`ifdef CSDF_ACC_SAT_EN
  logic              carry;
  logic [ACC_W-1:0]  sum_raw;
`endif

  always_comb begin
    in_sel  = in_data[grant_idx*DATA_W +: DATA_W];
    acc_sel = acc_q[grant_idx];
    last    = (cnt_q[grant_idx] == CntLast);
    in_ext  = '0;
    in_ext[DATA_W-1:0] = in_sel;
`ifdef CSDF_ACC_SAT_EN
    {carry, sum_raw} = {1'b0, acc_sel} + {1'b0, in_ext};
    sum = carry ? '1 : sum_raw;
`else
    sum = acc_sel + in_ext;
`endif
  end

  // Outputs: zero-latency pop and push on the final token of a batch.
  always_comb begin
    in_read  = grant_vld ? (NCH'(1) << grant_idx) : '0;
    out_wr   = grant_vld & last;
    out_data = out_wr ? {grant_idx, sum} : '0;
  end

  // Next-state: only the granted channel's context changes.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      acc_d[k] = acc_q[k];
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      if (last) begin
        cnt_d[grant_idx] = '0;
        acc_d[grant_idx] = '0;
      end else begin
        cnt_d[grant_idx] = cnt_q[grant_idx] + CntW'(1);
        acc_d[grant_idx] = sum;
      end
      rr_ptr_d = (grant_idx == PtrLast) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
        acc_q[k] <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
        acc_q[k] <= acc_d[k];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
